// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: fetches, decodes and sequences one 16-bit instruction at a time.
// Latency: 2 cycles (NOP) to 5 cycles (LW), plus one cycle per MemReady=0 cycle in FETCH/MEM.
// Backpressure: stalls in FETCH/MEM with MemReq held until MemReady; HALT parks until reset.
module multicycle_control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [3:0]  HALT_OP  = 4'hF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] MD,
    input  logic        MemReady,
    input  logic        Perform,
    output logic [15:0] PC,
    output logic        MemReq,
    output logic [15:0] IR,
    output logic [3:0]  r1A,
    output logic [3:0]  r2A,
    output logic [3:0]  WA,
    output logic [2:0]  ALUOp,
    output logic        SrcB,
    output logic        FU,
    output logic [2:0]  CC,
    output logic        LM,
    output logic        MW,
    output logic        RW,
    output logic [2:0]  RWSrc,
    output logic        Halted,
    output logic [2:0]  State
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_BRANCH = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_LUI  = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_JAL  = 4'hD;
    localparam logic [3:0] OP_NOP  = 4'hE;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [3:0]  op;
    logic        is_rtype;
    logic [15:0] offset;

    assign op       = ir[15:12];
    assign is_rtype = ~ir[15];
    assign offset   = {{8{ir[7]}}, ir[7:0]};

    // Next-state selection from the registered state, opcode and memory/branch handshakes
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op == HALT_OP)                    state_nxt = S_HALT;
                else if (op == OP_NOP)                state_nxt = S_FETCH;
                else if (op == OP_BR)                 state_nxt = S_BRANCH;
                else if (op == OP_LUI || op == OP_JAL) state_nxt = S_WB;
                else                                  state_nxt = S_EXEC;
            end
            S_EXEC:   state_nxt = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            S_MEM: begin
                if (!MemReady)        state_nxt = S_MEM;
                else if (op == OP_SW) state_nxt = S_FETCH;
                else                  state_nxt = S_WB;
            end
            S_WB:     state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // State, PC and instruction registers; PC-relative updates use the already-incremented PC
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 16'h0000;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && MemReady) begin
                ir <= MD;
                pc <= pc + 16'h0001;
            end else if (state == S_BRANCH && Perform) begin
                pc <= pc + offset;
            end else if (state == S_WB && op == OP_JAL) begin
                pc <= pc + offset;
            end
        end
    end

    // Datapath controls decoded from registered state and IR only
    always_comb begin
        ALUOp  = 3'b000;
        SrcB   = 1'b0;
        FU     = 1'b0;
        CC     = 3'b000;
        LM     = 1'b0;
        MW     = 1'b0;
        RW     = 1'b0;
        RWSrc  = 3'b000;
        Halted = 1'b0;
        case (state)
            S_EXEC: begin
                if (is_rtype) begin
                    ALUOp = op[2:0];
                    FU    = 1'b1;
                end else begin
                    SrcB = 1'b1;
                    FU   = (op == OP_ADDI);
                end
            end
            S_MEM: begin
                SrcB = 1'b1;
                LM   = 1'b1;
                MW   = (op == OP_SW);
            end
            S_WB: begin
                RW = 1'b1;
                // keep the ALU inputs stable so the ALU result is still valid for write-back
                if (is_rtype) begin
                    ALUOp = op[2:0];
                end else if (op == OP_ADDI) begin
                    SrcB = 1'b1;
                end
                if (op == OP_LW)       RWSrc = 3'b001;
                else if (op == OP_LUI) RWSrc = 3'b010;
                else if (op == OP_JAL) RWSrc = 3'b011;
                else                   RWSrc = 3'b000;
            end
            S_BRANCH: CC = ir[11:9];
            S_HALT:   Halted = 1'b1;
            default: ;
        endcase
    end

    // Request is gated by reset so an aborted access disappears immediately
    assign MemReq = RESET && (state == S_FETCH || state == S_MEM);
    assign PC     = pc;
    assign IR     = ir;
    assign r1A    = ir[7:4];
    assign r2A    = ir[3:0];
    assign WA     = ir[11:8];
    assign State  = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: table of per-cycle vectors plus hand sequences.
// Latency: inputs applied at negedge, outputs checked 1 time unit later, state advances at posedge.
// Backpressure: MemReady driven low by the vectors to exercise FETCH/MEM stalls.
module tb_multicycle_control_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] MD;
    logic        MemReady;
    logic        Perform;
    logic [15:0] PC;
    logic        MemReq;
    logic [15:0] IR;
    logic [3:0]  r1A;
    logic [3:0]  r2A;
    logic [3:0]  WA;
    logic [2:0]  ALUOp;
    logic        SrcB;
    logic        FU;
    logic [2:0]  CC;
    logic        LM;
    logic        MW;
    logic        RW;
    logic [2:0]  RWSrc;
    logic        Halted;
    logic [2:0]  State;

    multicycle_control_unit #(.RESET_PC(16'h0000), .HALT_OP(4'hF)) dut (
        .CLK(CLK), .RESET(RESET), .MD(MD), .MemReady(MemReady), .Perform(Perform),
        .PC(PC), .MemReq(MemReq), .IR(IR), .r1A(r1A), .r2A(r2A), .WA(WA),
        .ALUOp(ALUOp), .SrcB(SrcB), .FU(FU), .CC(CC), .LM(LM), .MW(MW), .RW(RW),
        .RWSrc(RWSrc), .Halted(Halted), .State(State)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] md;
        logic        mr;
        logic        pf;
        logic [2:0]  st;
        logic [15:0] pc;
        logic [15:0] ctl;
        logic [3:0]  wa;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // control bundle: {MemReq,LM,MW,RW,FU,SrcB,ALUOp,RWSrc,CC,Halted}
    function automatic logic [15:0] mk(input logic mreq, input logic lm, input logic mw,
                                       input logic rw, input logic fu, input logic srcb,
                                       input logic [2:0] aop, input logic [2:0] rws,
                                       input logic [2:0] cc, input logic hlt);
        return {mreq, lm, mw, rw, fu, srcb, aop, rws, cc, hlt};
    endfunction

    function automatic vec_t mkv(input logic [15:0] md, input logic mr, input logic pf,
                                 input logic [2:0] st, input logic [15:0] pc,
                                 input logic [15:0] ctl, input logic [3:0] wa);
        vec_t v;
        v.md = md; v.mr = mr; v.pf = pf; v.st = st; v.pc = pc; v.ctl = ctl; v.wa = wa;
        return v;
    endfunction

    task automatic compare(input string name, input vec_t v);
        logic [15:0] act_ctl;
        act_ctl = {MemReq, LM, MW, RW, FU, SrcB, ALUOp, RWSrc, CC, Halted};
        n_vec++;
        if (State !== v.st || PC !== v.pc || act_ctl !== v.ctl || WA !== v.wa) begin
            n_err++;
            $display("FAIL %s: got state=%0d pc=%h ctl=%b wa=%h, want state=%0d pc=%h ctl=%b wa=%h",
                     name, State, PC, act_ctl, WA, v.st, v.pc, v.ctl, v.wa);
        end
    endtask

    // apply inputs at the current negedge, check 1 unit later, then move to next negedge
    task automatic step(input string name, input vec_t v);
        MD = v.md; MemReady = v.mr; Perform = v.pf;
        #1;
        compare(name, v);
        @(negedge CLK);
    endtask

    initial begin
        logic [15:0] c_f, c_0, c_br, c_h, c_exls, c_mem_lw, c_mem_sw;
        c_f      = mk(1,0,0,0,0,0,3'd0,3'd0,3'd0,0);
        c_0      = mk(0,0,0,0,0,0,3'd0,3'd0,3'd0,0);
        c_br     = mk(0,0,0,0,0,0,3'd0,3'd0,3'd7,0);
        c_h      = mk(0,0,0,0,0,0,3'd0,3'd0,3'd0,1);
        c_exls   = mk(0,0,0,0,0,1,3'd0,3'd0,3'd0,0);
        c_mem_lw = mk(1,1,0,0,0,1,3'd0,3'd0,3'd0,0);
        c_mem_sw = mk(1,1,1,0,0,1,3'd0,3'd0,3'd0,0);

        // ADD r0,r1,r2
        tbl.push_back(mkv(16'h0012,1,0, 3'd0,16'h0000, c_f, 4'h0));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0001, c_0, 4'h0));
        tbl.push_back(mkv(16'h0000,0,0, 3'd2,16'h0001, mk(0,0,0,0,1,0,3'd0,3'd0,3'd0,0), 4'h0));
        tbl.push_back(mkv(16'h0000,0,0, 3'd4,16'h0001, mk(0,0,0,1,0,0,3'd0,3'd0,3'd0,0), 4'h0));
        // LW r3 with three wait cycles in MEM
        tbl.push_back(mkv(16'h9314,1,0, 3'd0,16'h0001, c_f, 4'h0));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0002, c_0, 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd2,16'h0002, c_exls, 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd3,16'h0002, c_mem_lw, 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd3,16'h0002, c_mem_lw, 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd3,16'h0002, c_mem_lw, 4'h3));
        tbl.push_back(mkv(16'h0000,1,0, 3'd3,16'h0002, c_mem_lw, 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd4,16'h0002, mk(0,0,0,1,0,0,3'd0,3'd1,3'd0,0), 4'h3));
        // three NOPs to reach PC=0005
        for (int k = 2; k < 5; k++) begin
            tbl.push_back(mkv(16'hE000,1,0, 3'd0,16'(k),   c_f, (k == 2) ? 4'h3 : 4'h0));
            tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'(k+1), c_0, 4'h0));
        end
        // BR cc=111 offset -2, taken
        tbl.push_back(mkv(16'hCEFE,1,0, 3'd0,16'h0005, c_f, 4'h0));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0006, c_0, 4'hE));
        tbl.push_back(mkv(16'h0000,0,1, 3'd5,16'h0006, c_br, 4'hE));
        // NOP at 4, then same BR not taken
        tbl.push_back(mkv(16'hE000,1,0, 3'd0,16'h0004, c_f, 4'hE));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0005, c_0, 4'h0));
        tbl.push_back(mkv(16'hCEFE,1,0, 3'd0,16'h0005, c_f, 4'h0));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0006, c_0, 4'hE));
        tbl.push_back(mkv(16'h0000,0,0, 3'd5,16'h0006, c_br, 4'hE));
        // BR +9 taken to reach PC=0010
        tbl.push_back(mkv(16'hCE09,1,0, 3'd0,16'h0006, c_f, 4'hE));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0007, c_0, 4'hE));
        tbl.push_back(mkv(16'h0000,0,1, 3'd5,16'h0007, c_br, 4'hE));
        // JAL r7, +0x10
        tbl.push_back(mkv(16'hD710,1,0, 3'd0,16'h0010, c_f, 4'hE));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0011, c_0, 4'h7));
        tbl.push_back(mkv(16'h0000,0,0, 3'd4,16'h0011, mk(0,0,0,1,0,0,3'd0,3'd3,3'd0,0), 4'h7));
        // LUI r5
        tbl.push_back(mkv(16'hB512,1,0, 3'd0,16'h0021, c_f, 4'h7));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0022, c_0, 4'h5));
        tbl.push_back(mkv(16'h0000,0,0, 3'd4,16'h0022, mk(0,0,0,1,0,0,3'd0,3'd2,3'd0,0), 4'h5));
        // ADDI rA
        tbl.push_back(mkv(16'h8A37,1,0, 3'd0,16'h0022, c_f, 4'h5));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0023, c_0, 4'hA));
        tbl.push_back(mkv(16'h0000,0,0, 3'd2,16'h0023, mk(0,0,0,0,1,1,3'd0,3'd0,3'd0,0), 4'hA));
        tbl.push_back(mkv(16'h0000,0,0, 3'd4,16'h0023, mk(0,0,0,1,0,1,3'd0,3'd0,3'd0,0), 4'hA));
        // R-type op 5 into r3, fetch stalled one cycle
        tbl.push_back(mkv(16'h5345,0,0, 3'd0,16'h0023, c_f, 4'hA));
        tbl.push_back(mkv(16'h5345,1,0, 3'd0,16'h0023, c_f, 4'hA));
        tbl.push_back(mkv(16'h0000,0,0, 3'd1,16'h0024, c_0, 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd2,16'h0024, mk(0,0,0,0,1,0,3'd5,3'd0,3'd0,0), 4'h3));
        tbl.push_back(mkv(16'h0000,0,0, 3'd4,16'h0024, mk(0,0,0,1,0,0,3'd5,3'd0,3'd0,0), 4'h3));

        // reset state
        RESET = 1'b0; MD = 16'h0000; MemReady = 1'b0; Perform = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        compare("reset", mkv(16'h0,0,0, 3'd0,16'h0000, c_0, 4'h0));
        RESET = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step($sformatf("tbl[%0d]", i), tbl[i]);

        // SW then HALT: MW only in MEM, PC frozen while halted
        step("sw_fetch", mkv(16'hA123,1,0, 3'd0,16'h0024, c_f, 4'h3));
        step("sw_dec",   mkv(16'h0000,0,0, 3'd1,16'h0025, c_0, 4'h1));
        step("sw_exec",  mkv(16'h0000,0,0, 3'd2,16'h0025, c_exls, 4'h1));
        step("sw_mem0",  mkv(16'h0000,0,0, 3'd3,16'h0025, c_mem_sw, 4'h1));
        step("sw_mem1",  mkv(16'h0000,0,0, 3'd3,16'h0025, c_mem_sw, 4'h1));
        step("sw_mem2",  mkv(16'h0000,1,0, 3'd3,16'h0025, c_mem_sw, 4'h1));
        step("hlt_fetch", mkv(16'hF000,1,0, 3'd0,16'h0025, c_f, 4'h1));
        step("hlt_dec",  mkv(16'h0000,1,1, 3'd1,16'h0026, c_0, 4'h0));
        for (int k = 0; k < 20; k++)
            step($sformatf("halt[%0d]", k), mkv(16'hFFFF,1,1, 3'd6,16'h0026, c_h, 4'h0));
        RESET = 1'b0;
        #1;
        compare("halt_reset", mkv(16'h0,0,0, 3'd0,16'h0000, c_0, 4'h0));
        @(negedge CLK);
        RESET = 1'b1;

        // reset in the middle of a SW memory access
        step("abort_fetch", mkv(16'hA000,1,0, 3'd0,16'h0000, c_f, 4'h0));
        step("abort_dec",   mkv(16'h0000,0,0, 3'd1,16'h0001, c_0, 4'h0));
        step("abort_exec",  mkv(16'h0000,0,0, 3'd2,16'h0001, c_exls, 4'h0));
        MD = 16'h0000; MemReady = 1'b0; Perform = 1'b0;
        #1;
        compare("abort_mem", mkv(16'h0,0,0, 3'd3,16'h0001, c_mem_sw, 4'h0));
        #2;
        RESET = 1'b0;
        #1;
        compare("abort_reset", mkv(16'h0,0,0, 3'd0,16'h0000, c_0, 4'h0));
        @(negedge CLK);
        compare("abort_held", mkv(16'h0,0,0, 3'd0,16'h0000, c_0, 4'h0));
        RESET = 1'b1;

        // branch back to FFFF, then fetch there and wrap to 0000
        step("wrap_br_fetch", mkv(16'hCEFE,1,0, 3'd0,16'h0000, c_f, 4'h0));
        step("wrap_br_dec",   mkv(16'h0000,0,0, 3'd1,16'h0001, c_0, 4'hE));
        step("wrap_br",       mkv(16'h0000,0,1, 3'd5,16'h0001, c_br, 4'hE));
        step("wrap_fetch",    mkv(16'hE000,1,0, 3'd0,16'hFFFF, c_f, 4'hE));
        step("wrap_dec",      mkv(16'h0000,0,0, 3'd1,16'h0000, c_0, 4'h0));
        step("wrap_after",    mkv(16'h0000,0,0, 3'd0,16'h0000, c_f, 4'h0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
